regfile_scoreboard: RTL and testbench

- Parametrised successor to the integer register file: N combinational read ports, one write port, hard-wired zero register, and write-to-read bypass.
- Adds a per-register busy scoreboard. Issue reserves a destination register with a valid/ready handshake; writeback clears the reservation. Read ports report operand hazards.
- Sits between the decode/issue stage and the writeback stage of the pipelined core.

---
 rtl/cpu_pkg.sv | 10 +
 rtl/regfile_scoreboard_if.sv | 33 +++
 rtl/regfile_scoreboard_busy.sv | 57 +++++
 rtl/regfile_scoreboard.sv | 64 ++++++
 tb/tb_regfile_scoreboard.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared core parameters and the register-index / word types
// used by decode, issue and writeback.
package cpu_pkg;
  localparam int DATA_WIDTH    = 32;
  localparam int NUM_REGISTERS = 32;
  localparam int IDX_W         = $clog2(NUM_REGISTERS);

  typedef logic [IDX_W-1:0]      reg_idx_t;
  typedef logic [DATA_WIDTH-1:0] word_t;
endpackage

// File: rtl/regfile_scoreboard_if.sv
// Issue/writeback/read bundle between decode, writeback and
// the register file scoreboard.
interface regfile_scoreboard_if #(
  parameter int DATA_WIDTH     = cpu_pkg::DATA_WIDTH,
  parameter int NUM_REGISTERS  = cpu_pkg::NUM_REGISTERS,
  parameter int NUM_READ_PORTS = 2
);
  localparam int IDX_W = $clog2(NUM_REGISTERS);
  localparam int CNT_W = $clog2(NUM_REGISTERS + 1);

  logic [NUM_READ_PORTS-1:0][IDX_W-1:0]      read_register;
  logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0] result;
  logic [NUM_READ_PORTS-1:0]                 read_busy;
  logic [IDX_W-1:0]                          write_register;
  logic [DATA_WIDTH-1:0]                     write_data;
  logic                                      write_data_valid;
  logic [IDX_W-1:0]                          reserve_register;
  logic                                      reserve_valid;
  logic                                      reserve_ready;
  logic [CNT_W-1:0]                          busy_count;

  modport master (
    output read_register, write_register, write_data,
    output write_data_valid, reserve_register, reserve_valid,
    input  result, read_busy, reserve_ready, busy_count
  );

  modport slave (
    input  read_register, write_register, write_data,
    input  write_data_valid, reserve_register, reserve_valid,
    output result, read_busy, reserve_ready, busy_count
  );
endinterface

// File: rtl/regfile_scoreboard_busy.sv
// Per-register busy bits, reservation handshake and the
// running count of outstanding destinations.
module regfile_scoreboard_busy #(
  parameter  int NUM_REGISTERS = 32,
  parameter  int ZERO_REG      = 1,
  localparam int IDX_W         = $clog2(NUM_REGISTERS),
  localparam int CNT_W         = $clog2(NUM_REGISTERS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IDX_W-1:0]         i_wr_idx,
  input  logic                     i_wr_en,
  input  logic [IDX_W-1:0]         i_rsv_idx,
  input  logic                     i_rsv_valid,
  output logic [NUM_REGISTERS-1:0] o_busy,
  output logic                     o_ready,
  output logic [CNT_W-1:0]         o_count
);
  logic [NUM_REGISTERS-1:0] r_busy;
  logic [CNT_W-1:0]         r_count;
  logic [NUM_REGISTERS-1:0] w_set;
  logic [NUM_REGISTERS-1:0] w_clr;
  logic w_rsv_zero;
  logic w_wr_hit;
  logic w_fire;
  logic w_inc;
  logic w_dec;

  always_comb begin
    w_set      = '0;
    w_clr      = '0;
    w_rsv_zero = (ZERO_REG != 0) && (i_rsv_idx == '0);
    w_wr_hit   = i_wr_en && (i_wr_idx == i_rsv_idx);
    o_ready    = !r_busy[i_rsv_idx] || w_wr_hit || w_rsv_zero;
    w_fire     = i_rsv_valid && o_ready && !w_rsv_zero;
    if (w_fire)
      w_set[i_rsv_idx] = 1'b1;
    if (i_wr_en)
      w_clr[i_wr_idx] = 1'b1;
    // a retire and re-reserve of one index leaves the count alone
    w_inc = w_fire && !r_busy[i_rsv_idx];
    w_dec = i_wr_en && r_busy[i_wr_idx] && !(w_fire && w_wr_hit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      r_busy  <= (r_busy & ~w_clr) | w_set;
      r_count <= r_count + CNT_W'(w_inc) - CNT_W'(w_dec);
    end
  end

  assign o_busy  = r_busy;
  assign o_count = r_count;
endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with N read ports, write bypass and a
// busy scoreboard for in-flight destinations.
module regfile_scoreboard #(
  parameter int DATA_WIDTH     = cpu_pkg::DATA_WIDTH,
  parameter int NUM_REGISTERS  = cpu_pkg::NUM_REGISTERS,
  parameter int NUM_READ_PORTS = 2,
  parameter int ZERO_REG       = 1
) (
  input logic                 clk,
  input logic                 rst,
  regfile_scoreboard_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REGISTERS);

  logic [DATA_WIDTH-1:0]    r_data [NUM_REGISTERS];
  logic [NUM_REGISTERS-1:0] w_busy;
  logic                     w_wr_en;

  assign w_wr_en = bus.write_data_valid &&
    !((ZERO_REG != 0) && (bus.write_register == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGISTERS; i++)
        r_data[i] <= '0;
    end else if (w_wr_en) begin
      r_data[bus.write_register] <= bus.write_data;
    end
  end

  always_comb begin
    bus.result    = '0;
    bus.read_busy = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      logic [IDX_W-1:0] idx;
      idx = bus.read_register[p];
      if ((ZERO_REG != 0) && (idx == '0)) begin
        bus.result[p]    = '0;
        bus.read_busy[p] = 1'b0;
      end else if (w_wr_en && (bus.write_register == idx)) begin
        bus.result[p]    = bus.write_data;
        bus.read_busy[p] = 1'b0;
      end else begin
        bus.result[p]    = r_data[idx];
        bus.read_busy[p] = w_busy[idx];
      end
    end
  end

  regfile_scoreboard_busy #(
    .NUM_REGISTERS (NUM_REGISTERS),
    .ZERO_REG      (ZERO_REG)
  ) u_busy (
    .clk         (clk),
    .rst         (rst),
    .i_wr_idx    (bus.write_register),
    .i_wr_en     (w_wr_en),
    .i_rsv_idx   (bus.reserve_register),
    .i_rsv_valid (bus.reserve_valid),
    .o_busy      (w_busy),
    .o_ready     (bus.reserve_ready),
    .o_count     (bus.busy_count)
  );
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed per-cycle vector table plus fill and reset sequences.
module tb_regfile_scoreboard;
  import cpu_pkg::*;

  typedef struct {
    logic     rst;
    reg_idx_t rr0;
    reg_idx_t rr1;
    logic     wv;
    reg_idx_t wi;
    word_t    wd;
    logic     rv;
    reg_idx_t ri;
    word_t    e0;
    word_t    e1;
    logic     eb0;
    logic     eb1;
    logic     erdy;
    int       ecnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  regfile_scoreboard_if bus ();

  regfile_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  function automatic vec_t mk(
    input logic rs, input int r0, input int r1,
    input logic wv, input int wi, input word_t wd,
    input logic rv, input int ri,
    input word_t e0, input word_t e1,
    input logic eb0, input logic eb1,
    input logic erdy, input int ecnt
  );
    vec_t v;
    v.rst = rs;   v.rr0 = reg_idx_t'(r0); v.rr1 = reg_idx_t'(r1);
    v.wv  = wv;   v.wi  = reg_idx_t'(wi); v.wd  = wd;
    v.rv  = rv;   v.ri  = reg_idx_t'(ri);
    v.e0  = e0;   v.e1  = e1;
    v.eb0 = eb0;  v.eb1 = eb1;
    v.erdy = erdy; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string nm, input int row,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%h want=%h", nm, row, act, exp);
    end
  endtask

  // drive one cycle, check combinational/registered outputs, clock it
  task automatic apply(input vec_t v, input int row);
    rst                  = v.rst;
    bus.read_register[0] = v.rr0;
    bus.read_register[1] = v.rr1;
    bus.write_data_valid = v.wv;
    bus.write_register   = v.wi;
    bus.write_data       = v.wd;
    bus.reserve_valid    = v.rv;
    bus.reserve_register = v.ri;
    #1;
    if (!v.rst) begin
      chk("result0", row, bus.result[0], v.e0);
      chk("result1", row, bus.result[1], v.e1);
      chk("busy0", row, 32'(bus.read_busy[0]), 32'(v.eb0));
      chk("busy1", row, 32'(bus.read_busy[1]), 32'(v.eb1));
      chk("ready", row, 32'(bus.reserve_ready), 32'(v.erdy));
      chk("count", row, 32'(bus.busy_count), v.ecnt);
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b1;
    bus.read_register    = '0;
    bus.write_data_valid = 1'b0;
    bus.write_register   = '0;
    bus.write_data       = '0;
    bus.reserve_valid    = 1'b0;
    bus.reserve_register = '0;
    repeat (2) @(posedge clk);
    #1;

    // rst r0 r1 wv wi wd rv ri | e0 e1 eb0 eb1 rdy cnt
    tbl.push_back(mk(0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 3, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 3, 0, 1, 3, 32'hDEADBEEF, 0, 3,
                     32'hDEADBEEF, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 3,
                     32'hDEADBEEF, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 7, 3, 0, 0, 0, 1, 7,
                     0, 32'hDEADBEEF, 0, 0, 1, 0));
    tbl.push_back(mk(0, 7, 0, 0, 0, 0, 1, 7, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 7, 0, 1, 7, 32'h77, 1, 7,
                     32'h77, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 7, 0, 0, 0, 0, 0, 7, 32'h77, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 7, 0, 1, 7, 32'h78, 0, 7,
                     32'h78, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 7, 0, 0, 0, 0, 0, 7, 32'h78, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 32'h12345678, 1, 0,
                     0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 3, 10, 1, 10, 32'h55, 0, 0,
                     32'hDEADBEEF, 32'h55, 0, 0, 1, 0));
    tbl.push_back(mk(0, 10, 3, 0, 0, 0, 0, 0,
                     32'h55, 32'hDEADBEEF, 0, 0, 1, 0));
    tbl.push_back(mk(0, 12, 0, 1, 12, 32'hC, 1, 12,
                     32'hC, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 12, 0, 0, 0, 0, 0, 12, 32'hC, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 12, 0, 1, 12, 32'hD, 0, 12,
                     32'hD, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 12, 0, 0, 0, 0, 0, 12, 32'hD, 0, 0, 0, 1, 0));

    foreach (tbl[i]) apply(tbl[i], i);

    // fill x1..x31 one per cycle
    for (int i = 1; i < 32; i++)
      apply(mk(0, 0, 0, 0, 0, 0, 1, i, 0, 0, 0, 0, 1, i - 1), 100 + i);
    apply(mk(0, 31, 1, 0, 0, 0, 1, 5, 0, 0, 1, 1, 0, 31), 200);
    apply(mk(0, 3, 7, 0, 0, 0, 1, 0,
             32'hDEADBEEF, 32'h78, 1, 1, 1, 31), 201);
    apply(mk(0, 12, 0, 0, 0, 0, 0, 0, 32'hD, 0, 1, 0, 1, 31), 202);

    // reset in the middle of traffic
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 300);
    apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0), 301);
    apply(mk(0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 1, 1), 302);
    apply(mk(0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 1, 2), 303);
    apply(mk(0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0, 1, 3), 304);
    apply(mk(0, 3, 1, 1, 3, 32'h33, 0, 0, 32'h33, 0, 0, 1, 1, 4), 305);
    apply(mk(0, 3, 4, 0, 0, 0, 0, 0, 32'h33, 0, 0, 1, 1, 4), 306);
    apply(mk(1, 0, 0, 1, 2, 32'hAA, 1, 9, 0, 0, 0, 0, 0, 0), 307);
    apply(mk(0, 2, 9, 0, 0, 0, 0, 9, 0, 0, 0, 0, 1, 0), 308);
    apply(mk(0, 3, 4, 0, 0, 0, 0, 4, 0, 0, 0, 0, 1, 0), 309);
    apply(mk(0, 1, 6, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0), 310);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
